// File: rtl/imm_encoder.sv
// Sequential ARM operand-2 immediate encoder: searches rotations 0..15 for an
// {rot, imm8} encoding of a 32-bit constant (direct form) or of its complement (MVN form).
module imm_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic        use_mvn,
    output logic [11:0] shifter_operand
);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t      state, state_nx;
    logic [31:0] v_reg;
    logic [3:0]  rot_cnt;
    logic [5:0]  sh;
    logic [31:0] t, u;
    logic        hit_t, hit_u;

    // Left-rotate by 2*rot undoes the encoding's right-rotate; a shift by 32 yields 0,
    // so the rot=0 case needs no special handling.
    always_comb begin
        sh    = {1'b0, rot_cnt, 1'b0};
        t     = (v_reg << sh) | (v_reg >> (6'd32 - sh));
        u     = (~v_reg << sh) | (~v_reg >> (6'd32 - sh));
        hit_t = (t[31:8] == 24'h0);
        hit_u = (u[31:8] == 24'h0);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SEARCH;
            SEARCH:  if (hit_t || hit_u || rot_cnt == 4'd15) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_reg           <= 32'h0;
            rot_cnt         <= 4'd0;
            valid           <= 1'b0;
            use_mvn         <= 1'b0;
            shifter_operand <= 12'h000;
        end else begin
            case (state)
                IDLE: if (start) begin
                    v_reg   <= value;
                    rot_cnt <= 4'd0;
                end
                SEARCH: begin
                    // Direct form checked first so it wins a tie at equal rot.
                    if (hit_t) begin
                        valid           <= 1'b1;
                        use_mvn         <= 1'b0;
                        shifter_operand <= {rot_cnt, t[7:0]};
                    end else if (hit_u) begin
                        valid           <= 1'b1;
                        use_mvn         <= 1'b1;
                        shifter_operand <= {rot_cnt, u[7:0]};
                    end else if (rot_cnt == 4'd15) begin
                        valid           <= 1'b0;
                        use_mvn         <= 1'b0;
                        shifter_operand <= 12'h000;
                    end else begin
                        rot_cnt <= rot_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed vector table, random constants against a
// mask-based reference model, and start-while-busy / mid-search reset sequences.
module tb_imm_encoder;

    logic        clk = 0;
    logic        rst;
    logic        start;
    logic [31:0] value;
    logic        busy, done, valid, use_mvn;
    logic [11:0] shifter_operand;

    int nvec = 0;
    int nerr = 0;

    imm_encoder dut (
        .clk(clk), .rst(rst), .start(start), .value(value),
        .busy(busy), .done(done), .valid(valid), .use_mvn(use_mvn),
        .shifter_operand(shifter_operand)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] v;
        int          cyc;
        logic        ok;
        logic        mvn;
        logic [11:0] op;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int s);
        if (s == 0) return x;
        return (x >> s) | (x << (32 - s));
    endfunction

    // An encoding at rot r exists iff the word only has bits inside the
    // 8-bit window that imm8 lands in after rotating right by 2r.
    function automatic vec_t model(input logic [31:0] v);
        vec_t r;
        logic [31:0] w, mask;
        bit found = 0;
        r.v = v; r.cyc = 17; r.ok = 0; r.mvn = 0; r.op = 12'h000;
        for (int rot = 0; rot < 16 && !found; rot++) begin
            for (int f = 0; f < 2 && !found; f++) begin
                w    = f ? ~v : v;
                mask = rotr(32'hFF, 2 * rot);
                if ((w & ~mask) == 0) begin
                    found = 1;
                    r.ok  = 1;
                    r.mvn = (f == 1);
                    r.cyc = rot + 2;
                    for (int k = 0; k < 256; k++)
                        if (rotr(k, 2 * rot) == w) r.op = {rot[3:0], k[7:0]};
                end
            end
        end
        return r;
    endfunction

    // Called at #1 after an edge, in cycle cyc0; returns the cycle in which done is seen.
    task automatic wait_done(input int cyc0, output int cyc);
        cyc = cyc0;
        forever begin
            @(negedge clk);
            if (done || cyc > 40) break;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run(input string name, input vec_t e);
        int cyc;
        start = 1; value = e.v;
        @(posedge clk); #1;
        start = 0; value = $urandom;
        @(negedge clk);
        chk({name, " busy_c1"}, busy, 1);
        @(posedge clk); #1;
        wait_done(2, cyc);
        chk({name, " done_cycle"}, cyc, e.cyc);
        chk({name, " valid"}, valid, e.ok);
        chk({name, " use_mvn"}, use_mvn, e.mvn);
        chk({name, " operand"}, shifter_operand, e.op);
        @(posedge clk); #1;
        chk({name, " idle_after"}, {busy, done}, 0);
    endtask

    initial begin
        vec_t tbl[6];
        vec_t e;
        int cyc;
        logic [31:0] rv;
        bit saw_done;

        tbl[0] = '{32'h00000000, 2,  1, 0, 12'h000};
        tbl[1] = '{32'h000000FF, 2,  1, 0, 12'h0FF};
        tbl[2] = '{32'hF000000F, 4,  1, 0, 12'h2FF};
        tbl[3] = '{32'hFF000000, 6,  1, 0, 12'h4FF};
        tbl[4] = '{32'hFFFFFF00, 2,  1, 1, 12'h0FF};
        tbl[5] = '{32'h00000102, 17, 0, 0, 12'h000};

        rst = 0; start = 1; value = 32'h12345678;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset outputs", {busy, done, valid, use_mvn, shifter_operand}, 0);
        #1 rst = 1; start = 0;
        @(posedge clk); #1;

        foreach (tbl[i]) run($sformatf("tbl%0d", i), tbl[i]);

        for (int i = 0; i < 150; i++) begin
            case (i % 3)
                0: rv = $urandom;
                1: rv = rotr($urandom_range(0, 255), 2 * $urandom_range(0, 15));
                default: rv = ~rotr($urandom_range(0, 255), 2 * $urandom_range(0, 15));
            endcase
            e = model(rv);
            run($sformatf("rnd%0d(%08h)", i, rv), e);
        end

        // start pulsed in cycle 3 while busy is ignored
        start = 1; value = 32'hFF000000;
        @(posedge clk); #1; start = 0;
        @(posedge clk); #1;
        @(posedge clk); #1; start = 1; value = 32'h000000FF;
        @(posedge clk); #1; start = 0;
        wait_done(4, cyc);
        chk("busy_start done_cycle", cyc, 6);
        chk("busy_start operand", shifter_operand, 12'h4FF);
        chk("busy_start valid", valid, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy_start no_restart", busy, 0);
        @(posedge clk); #1;

        // reset in cycle 3 of a search discards it
        start = 1; value = 32'hFF000000;
        @(posedge clk); #1; start = 0;
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        chk("midrst outputs", {busy, done, valid, use_mvn, shifter_operand}, 0);
        saw_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        #1 rst = 1;
        repeat (6) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        chk("midrst no_done", saw_done, 0);
        @(posedge clk); #1;
        run("after_rst", model(32'h0003FC00));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
